// File: rtl/mem_access_stage_if.sv
// Bundle for the memory stage. It carries the execute-result handshake, the byte-wide RAM port and the write-back port.
// Handshake: a result transfers on a rising edge where i_valid & o_ready; o_ready is registered and is never combinational on i_valid.
`timescale 1ns/1ps
interface mem_access_stage_if #(
  parameter int N      = 32,
  parameter int ADDR_W = 10
);
  logic              i_valid;
  logic              o_ready;
  logic              i_s_mem_r_en;
  logic              i_s_mem_w_en;
  logic              i_s_wb_en;
  logic [3:0]        i_rd;
  logic [N-1:0]      i_alu_res;
  logic [N-1:0]      i_v_st;
  logic [ADDR_W-1:0] o_mem_addr;
  logic              o_mem_we;
  logic              o_mem_re;
  logic [7:0]        o_mem_wdata;
  logic [7:0]        i_mem_rdata;
  logic              o_wb_valid;
  logic              o_wb_en;
  logic [3:0]        o_wb_rd;
  logic [N-1:0]      o_wb_data;
  logic              o_fault;
  logic [1:0]        o_dbg_state;

  modport slave (
    input  i_valid, i_s_mem_r_en, i_s_mem_w_en, i_s_wb_en, i_rd, i_alu_res, i_v_st, i_mem_rdata,
    output o_ready, o_mem_addr, o_mem_we, o_mem_re, o_mem_wdata,
    output o_wb_valid, o_wb_en, o_wb_rd, o_wb_data, o_fault, o_dbg_state
  );

  modport master (
    output i_valid, i_s_mem_r_en, i_s_mem_w_en, i_s_wb_en, i_rd, i_alu_res, i_v_st, i_mem_rdata,
    input  o_ready, o_mem_addr, o_mem_we, o_mem_re, o_mem_wdata,
    input  o_wb_valid, o_wb_en, o_wb_rd, o_wb_data, o_fault, o_dbg_state
  );
endinterface

// File: rtl/mem_access_stage.sv
// ARM32 memory stage. LDR/STR run as four big-endian byte accesses on a byte-wide RAM.
// Every output is registered. The current FSM state is exported on o_dbg_state.
`timescale 1ns/1ps
module mem_access_stage #(
  parameter int N        = 32,
  parameter int ADDR_W   = 10,
  parameter int MEM_BASE = 1024
) (
  input  logic               clk,
  input  logic               reset_n,
  mem_access_stage_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_STORE, S_LOAD, S_DONE} state_t;

  state_t            r_state, w_state_n;
  logic [2:0]        r_k, w_k_n;
  logic [3:0]        r_rd, w_rd_n;
  logic              r_wben, w_wben_n;
  logic [N-1:0]      r_alu, w_alu_n;
  logic [N-1:0]      r_st, w_st_n;
  logic [N-1:0]      r_ld, w_ld_n;

  logic              r_ready, w_ready_n;
  logic              r_mem_we, w_we_n;
  logic              r_mem_re, w_re_n;
  logic [ADDR_W-1:0] r_mem_addr, w_addr_n;
  logic [7:0]        r_mem_wdata, w_wdata_n;
  logic              r_wb_valid, w_wbv_n;
  logic              r_wb_en, w_wbe_n;
  logic [3:0]        r_wb_rd, w_wbrd_n;
  logic [N-1:0]      r_wb_data, w_wbd_n;
  logic              r_fault, w_fault_n;

  logic              w_accept;
  logic [N-1:0]      w_word;
  logic [N-1:0]      w_byte0;
  logic              w_is_mem;
  logic              w_oob;
  logic              w_fault;

  // A word below MEM_BASE wraps to a huge byte0, so one range test covers both ends.
  assign w_accept = bus.i_valid & r_ready;
  assign w_word   = {bus.i_alu_res[N-1:2], 2'b00};
  assign w_byte0  = w_word - N'(MEM_BASE);
  assign w_is_mem = bus.i_s_mem_r_en | bus.i_s_mem_w_en;
  assign w_oob    = |w_byte0[N-1:ADDR_W];
  assign w_fault  = (bus.i_s_mem_r_en & bus.i_s_mem_w_en) | (w_is_mem & w_oob);

  always_comb begin
    w_state_n = r_state;
    w_k_n     = r_k;
    w_rd_n    = r_rd;
    w_wben_n  = r_wben;
    w_alu_n   = r_alu;
    w_st_n    = r_st;
    w_ld_n    = r_ld;
    w_ready_n = 1'b0;
    w_we_n    = 1'b0;
    w_re_n    = 1'b0;
    w_addr_n  = '0;
    w_wdata_n = '0;
    w_wbv_n   = 1'b0;
    w_wbe_n   = 1'b0;
    w_wbrd_n  = '0;
    w_wbd_n   = '0;
    w_fault_n = 1'b0;
    case (r_state)
      S_STORE: begin
        if (r_k == 3'd3) begin
          w_state_n = S_DONE;
          w_ready_n = 1'b1;
          w_wbv_n   = 1'b1;
          w_wbrd_n  = r_rd;
          w_wbd_n   = r_alu;
        end else begin
          w_k_n     = r_k + 3'd1;
          w_we_n    = 1'b1;
          w_addr_n  = r_mem_addr + ADDR_W'(1);
          w_wdata_n = r_st[N-1 -: 8];
          w_st_n    = r_st << 8;
        end
      end
      S_LOAD: begin
        // Read data lags the strobe by one cycle, so capture runs at k = 1..4.
        if (r_k != 3'd0) w_ld_n = {r_ld[N-9:0], bus.i_mem_rdata};
        if (r_k < 3'd3) begin
          w_k_n    = r_k + 3'd1;
          w_re_n   = 1'b1;
          w_addr_n = r_mem_addr + ADDR_W'(1);
        end else if (r_k == 3'd3) begin
          w_k_n = 3'd4;
        end else begin
          w_state_n = S_DONE;
          w_ready_n = 1'b1;
          w_wbv_n   = 1'b1;
          w_wbe_n   = r_wben;
          w_wbrd_n  = r_rd;
          w_wbd_n   = w_ld_n;
        end
      end
      default: begin
        if (w_accept) begin
          w_k_n    = 3'd0;
          w_rd_n   = bus.i_rd;
          w_wben_n = bus.i_s_wb_en;
          w_alu_n  = bus.i_alu_res;
          w_ld_n   = '0;
          if (w_fault) begin
            w_state_n = S_DONE;
            w_ready_n = 1'b1;
            w_wbv_n   = 1'b1;
            w_fault_n = 1'b1;
            w_wbrd_n  = bus.i_rd;
          end else if (bus.i_s_mem_w_en) begin
            w_state_n = S_STORE;
            w_we_n    = 1'b1;
            w_addr_n  = w_byte0[ADDR_W-1:0];
            w_wdata_n = bus.i_v_st[N-1 -: 8];
            w_st_n    = bus.i_v_st << 8;
          end else if (bus.i_s_mem_r_en) begin
            w_state_n = S_LOAD;
            w_re_n    = 1'b1;
            w_addr_n  = w_byte0[ADDR_W-1:0];
          end else begin
            w_state_n = S_DONE;
            w_ready_n = 1'b1;
            w_wbv_n   = 1'b1;
            w_wbe_n   = bus.i_s_wb_en;
            w_wbrd_n  = bus.i_rd;
            w_wbd_n   = bus.i_alu_res;
          end
        end else begin
          w_state_n = S_IDLE;
          w_ready_n = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_k         <= '0;
      r_rd        <= '0;
      r_wben      <= 1'b0;
      r_alu       <= '0;
      r_st        <= '0;
      r_ld        <= '0;
      r_ready     <= 1'b1;
      r_mem_we    <= 1'b0;
      r_mem_re    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_wb_valid  <= 1'b0;
      r_wb_en     <= 1'b0;
      r_wb_rd     <= '0;
      r_wb_data   <= '0;
      r_fault     <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_k         <= w_k_n;
      r_rd        <= w_rd_n;
      r_wben      <= w_wben_n;
      r_alu       <= w_alu_n;
      r_st        <= w_st_n;
      r_ld        <= w_ld_n;
      r_ready     <= w_ready_n;
      r_mem_we    <= w_we_n;
      r_mem_re    <= w_re_n;
      r_mem_addr  <= w_addr_n;
      r_mem_wdata <= w_wdata_n;
      r_wb_valid  <= w_wbv_n;
      r_wb_en     <= w_wbe_n;
      r_wb_rd     <= w_wbrd_n;
      r_wb_data   <= w_wbd_n;
      r_fault     <= w_fault_n;
    end
  end

  assign bus.o_ready     = r_ready;
  assign bus.o_mem_we    = r_mem_we;
  assign bus.o_mem_re    = r_mem_re;
  assign bus.o_mem_addr  = r_mem_addr;
  assign bus.o_mem_wdata = r_mem_wdata;
  assign bus.o_wb_valid  = r_wb_valid;
  assign bus.o_wb_en     = r_wb_en;
  assign bus.o_wb_rd     = r_wb_rd;
  assign bus.o_wb_data   = r_wb_data;
  assign bus.o_fault     = r_fault;
  assign bus.o_dbg_state = r_state;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: a byte RAM on the memory port, directed scenarios and a random run.
// The random run is scored against an op-level reference model.
`timescale 1ns/1ps
module tb_mem_access_stage;
  localparam int N        = 32;
  localparam int ADDR_W   = 10;
  localparam int MEM_BASE = 1024;
  localparam int DEPTH    = 1 << ADDR_W;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  mem_access_stage_if #(.N(N), .ADDR_W(ADDR_W)) bus();
  mem_access_stage #(.N(N), .ADDR_W(ADDR_W), .MEM_BASE(MEM_BASE)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  // Byte RAM seen by the DUT, plus the reference model's own copy
  logic [7:0]        ram     [DEPTH];
  logic [7:0]        ref_mem [DEPTH];
  logic              pl_en   = 1'b0;
  logic [ADDR_W-1:0] pl_addr = '0;
  logic [7:0]        pl_data = '0;
  logic [7:0]        rdata_q = '0;
  int                strobe_cnt = 0;

  always @(posedge clk) begin
    if (pl_en) ram[pl_addr] <= pl_data;
    else if (bus.o_mem_we) ram[bus.o_mem_addr] <= bus.o_mem_wdata;
    if (bus.o_mem_re) rdata_q <= ram[bus.o_mem_addr];
    if (bus.o_mem_we || bus.o_mem_re) strobe_cnt <= strobe_cnt + 1;
  end
  assign bus.i_mem_rdata = rdata_q;

  int n_checks = 0;
  int n_errors = 0;
  logic [37:0] exp_q[$];
  int          due_q[$];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic preload(input int a, input logic [7:0] d);
    pl_en = 1'b1; pl_addr = ADDR_W'(a); pl_data = d; ref_mem[a] = d;
    tick();
    pl_en = 1'b0;
  endtask

  task automatic set_op(input logic r, input logic w, input logic wb, input logic [3:0] rd,
                        input logic [31:0] alu, input logic [31:0] st);
    bus.i_s_mem_r_en = r; bus.i_s_mem_w_en = w; bus.i_s_wb_en = wb;
    bus.i_rd = rd; bus.i_alu_res = alu; bus.i_v_st = st; bus.i_valid = 1'b1;
  endtask

  // Presents one op, waits (bounded) for acceptance and returns in cycle C1
  task automatic issue(input logic r, input logic w, input logic wb, input logic [3:0] rd,
                       input logic [31:0] alu, input logic [31:0] st);
    int t = 0;
    set_op(r, w, wb, rd, alu, st);
    while (bus.o_ready !== 1'b1 && t < 20) begin tick(); t++; end
    n_checks++;
    if (bus.o_ready !== 1'b1) begin n_errors++; $display("FAIL issue_ready_timeout got=%b exp=1", bus.o_ready); end
    tick();
    bus.i_valid = 1'b0;
  endtask

  // Operation-level reference: effect on memory and the write-back record, plus latency in cycles
  task automatic model_exec(input logic r, input logic w, input logic wb, input logic [3:0] rd,
                            input logic [31:0] alu, input logic [31:0] st,
                            output logic [37:0] exp, output int lat, output int kind);
    logic [31:0] off;
    logic [31:0] data;
    off = (alu & ~32'h3) - 32'(MEM_BASE);
    if ((r && w) || ((r || w) && off >= 32'(DEPTH))) begin
      exp = {1'b1, 1'b0, rd, 32'h0}; lat = 1; kind = 3;
    end else if (w) begin
      for (int i = 0; i < 4; i++) ref_mem[int'(off) + i] = 8'(st >> (24 - 8 * i));
      exp = {1'b0, 1'b0, rd, alu}; lat = 5; kind = 1;
    end else if (r) begin
      data = 32'h0;
      for (int i = 0; i < 4; i++) data = (data << 8) | 32'(ref_mem[int'(off) + i]);
      exp = {1'b0, wb, rd, data}; lat = 6; kind = 2;
    end else begin
      exp = {1'b0, wb, rd, alu}; lat = 1; kind = 0;
    end
  endtask

  task automatic test_reset();
    set_op(0, 0, 0, 4'd0, 32'h0, 32'h0);
    bus.i_valid = 1'b0;
    reset_n = 1'b0;
    tick(); tick();
    n_checks++;
    if ({bus.o_ready, bus.o_mem_we, bus.o_mem_re, bus.o_wb_valid, bus.o_wb_en, bus.o_fault} !== 6'b100000) begin
      n_errors++; $display("FAIL reset_ctrl got=%b exp=100000",
        {bus.o_ready, bus.o_mem_we, bus.o_mem_re, bus.o_wb_valid, bus.o_wb_en, bus.o_fault});
    end
    n_checks++;
    if ({bus.o_wb_data, bus.o_wb_rd, bus.o_mem_addr, bus.o_mem_wdata} !== '0) begin
      n_errors++; $display("FAIL reset_data got=%h/%h/%h/%h exp=0", bus.o_wb_data, bus.o_wb_rd, bus.o_mem_addr, bus.o_mem_wdata);
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_store();
    logic [31:0] st = 32'hDEADBEEF;
    logic [7:0]  eb;
    issue(0, 1, 0, 4'd9, 32'h0000_0404, st);
    for (int k = 0; k < 4; k++) begin
      eb = 8'(st >> (24 - 8 * k));
      n_checks++;
      if ({bus.o_mem_we, bus.o_mem_re, bus.o_ready, bus.o_wb_valid} !== 4'b1000) begin
        n_errors++; $display("FAIL store_ctrl k=%0d we/re/rdy/wbv got=%b exp=1000", k,
          {bus.o_mem_we, bus.o_mem_re, bus.o_ready, bus.o_wb_valid});
      end
      n_checks++;
      if (bus.o_mem_addr !== ADDR_W'(4 + k) || bus.o_mem_wdata !== eb) begin
        n_errors++; $display("FAIL store_byte k=%0d got=%0d:%h exp=%0d:%h", k, bus.o_mem_addr, bus.o_mem_wdata, 4 + k, eb);
      end
      tick();
    end
    n_checks++;
    if ({bus.o_wb_valid, bus.o_wb_en, bus.o_fault, bus.o_ready, bus.o_mem_we} !== 5'b10010 ||
        bus.o_wb_data !== 32'h404 || bus.o_wb_rd !== 4'd9) begin
      n_errors++; $display("FAIL store_wb got=%b data=%h rd=%0d exp=10010 data=404 rd=9",
        {bus.o_wb_valid, bus.o_wb_en, bus.o_fault, bus.o_ready, bus.o_mem_we}, bus.o_wb_data, bus.o_wb_rd);
    end
    tick();
    n_checks++;
    if (bus.o_wb_valid !== 1'b0) begin n_errors++; $display("FAIL store_wb_pulse got=%b exp=0", bus.o_wb_valid); end
    n_checks++;
    if ({ram[4], ram[5], ram[6], ram[7]} !== st) begin
      n_errors++; $display("FAIL store_ram got=%h exp=%h", {ram[4], ram[5], ram[6], ram[7]}, st);
    end
  endtask

  task automatic test_load();
    preload(4, 8'h11); preload(5, 8'h22); preload(6, 8'h33); preload(7, 8'h44);
    issue(1, 0, 1, 4'd3, 32'h0000_0406, $urandom());
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if ({bus.o_mem_re, bus.o_mem_we, bus.o_ready} !== 3'b100 || bus.o_mem_addr !== ADDR_W'(4 + k)) begin
        n_errors++; $display("FAIL load_strobe k=%0d re/we/rdy got=%b addr=%0d exp=100 addr=%0d", k,
          {bus.o_mem_re, bus.o_mem_we, bus.o_ready}, bus.o_mem_addr, 4 + k);
      end
      tick();
    end
    n_checks++;
    if ({bus.o_mem_re, bus.o_wb_valid, bus.o_ready} !== 3'b000) begin
      n_errors++; $display("FAIL load_c5 re/wbv/rdy got=%b exp=000", {bus.o_mem_re, bus.o_wb_valid, bus.o_ready});
    end
    tick();
    n_checks++;
    if ({bus.o_wb_valid, bus.o_wb_en, bus.o_fault} !== 3'b110 || bus.o_wb_rd !== 4'd3 || bus.o_wb_data !== 32'h11223344) begin
      n_errors++; $display("FAIL load_wb got=%b rd=%0d data=%h exp=110 rd=3 data=11223344",
        {bus.o_wb_valid, bus.o_wb_en, bus.o_fault}, bus.o_wb_rd, bus.o_wb_data);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    set_op(0, 0, 1, 4'd2, 32'h7, 32'h0);
    tick();
    n_checks++;
    if ({bus.o_wb_valid, bus.o_wb_en, bus.o_ready, bus.o_mem_we, bus.o_mem_re} !== 5'b11100 ||
        bus.o_wb_data !== 32'h7 || bus.o_wb_rd !== 4'd2) begin
      n_errors++; $display("FAIL alu_wb got=%b data=%h rd=%0d exp=11100 data=7 rd=2",
        {bus.o_wb_valid, bus.o_wb_en, bus.o_ready, bus.o_mem_we, bus.o_mem_re}, bus.o_wb_data, bus.o_wb_rd);
    end
    set_op(0, 0, 0, 4'd5, 32'h1234, 32'h0);
    tick();
    n_checks++;
    if ({bus.o_wb_valid, bus.o_wb_en} !== 2'b10 || bus.o_wb_data !== 32'h1234 || bus.o_wb_rd !== 4'd5) begin
      n_errors++; $display("FAIL b2b_alu_wb got=%b data=%h rd=%0d exp=10 data=1234 rd=5",
        {bus.o_wb_valid, bus.o_wb_en}, bus.o_wb_data, bus.o_wb_rd);
    end
    set_op(0, 1, 0, 4'd1, 32'h408, 32'hCAFEF00D);
    tick();
    bus.i_valid = 1'b0;
    n_checks++;
    if ({bus.o_mem_we, bus.o_wb_valid} !== 2'b10 || bus.o_mem_addr !== ADDR_W'(8) || bus.o_mem_wdata !== 8'hCA) begin
      n_errors++; $display("FAIL b2b_store_start we/wbv got=%b addr=%0d wd=%h exp=10 addr=8 wd=ca",
        {bus.o_mem_we, bus.o_wb_valid}, bus.o_mem_addr, bus.o_mem_wdata);
    end
    repeat (5) tick();
  endtask

  task automatic test_fault();
    logic        fr [3] = '{1'b1, 1'b0, 1'b1};
    logic        fw [3] = '{1'b0, 1'b1, 1'b1};
    logic [31:0] fa [3] = '{32'h3FC, 32'h800, 32'h400};
    int s0;
    for (int i = 0; i < 3; i++) begin
      s0 = strobe_cnt;
      issue(fr[i], fw[i], 1'b1, 4'(10 + i), fa[i], 32'hA5A5A5A5);
      n_checks++;
      if ({bus.o_wb_valid, bus.o_fault, bus.o_wb_en, bus.o_ready} !== 4'b1101 ||
          bus.o_wb_data !== 32'h0 || bus.o_wb_rd !== 4'(10 + i)) begin
        n_errors++; $display("FAIL fault_wb case=%0d got=%b data=%h rd=%0d exp=1101 data=0 rd=%0d", i,
          {bus.o_wb_valid, bus.o_fault, bus.o_wb_en, bus.o_ready}, bus.o_wb_data, bus.o_wb_rd, 10 + i);
      end
      tick();
      n_checks++;
      if ({bus.o_wb_valid, bus.o_fault} !== 2'b00) begin
        n_errors++; $display("FAIL fault_pulse case=%0d got=%b exp=00", i, {bus.o_wb_valid, bus.o_fault});
      end
      tick();
      n_checks++;
      if (strobe_cnt !== s0) begin n_errors++; $display("FAIL fault_strobes case=%0d got=%0d exp=%0d", i, strobe_cnt, s0); end
    end
  endtask

  task automatic test_reset_mid();
    preload(0, 8'hA0); preload(1, 8'hA1); preload(2, 8'hA2); preload(3, 8'hA3);
    issue(0, 1, 0, 4'd0, 32'h400, 32'h55667788);
    n_checks++;
    if (bus.o_mem_we !== 1'b1 || bus.o_mem_addr !== '0 || bus.o_mem_wdata !== 8'h55) begin
      n_errors++; $display("FAIL rmid_c1 we=%b addr=%0d wd=%h exp we=1 addr=0 wd=55", bus.o_mem_we, bus.o_mem_addr, bus.o_mem_wdata);
    end
    tick();
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.o_ready, bus.o_mem_we, bus.o_mem_re, bus.o_wb_valid, bus.o_wb_en, bus.o_fault} !== 6'b100000 ||
        bus.o_mem_addr !== '0 || bus.o_mem_wdata !== '0) begin
      n_errors++; $display("FAIL rmid_outputs got=%b addr=%0d wd=%h exp=100000 addr=0 wd=0",
        {bus.o_ready, bus.o_mem_we, bus.o_mem_re, bus.o_wb_valid, bus.o_wb_en, bus.o_fault}, bus.o_mem_addr, bus.o_mem_wdata);
    end
    tick();
    reset_n = 1'b1;
    tick();
    n_checks++;
    if ({ram[0], ram[1], ram[2], ram[3]} !== 32'h55A1A2A3) begin
      n_errors++; $display("FAIL rmid_ram got=%h exp=55a1a2a3", {ram[0], ram[1], ram[2], ram[3]});
    end
    issue(1, 0, 1, 4'd6, 32'h400, 32'h0);
    repeat (5) tick();
    n_checks++;
    if ({bus.o_wb_valid, bus.o_wb_en, bus.o_fault} !== 3'b110 || bus.o_wb_data !== 32'h55A1A2A3 || bus.o_wb_rd !== 4'd6) begin
      n_errors++; $display("FAIL rmid_load got=%b data=%h rd=%0d exp=110 data=55a1a2a3 rd=6",
        {bus.o_wb_valid, bus.o_wb_en, bus.o_fault}, bus.o_wb_data, bus.o_wb_rd);
    end
    tick();
  endtask

  task automatic rand_op();
    int sel;
    logic [31:0] a;
    sel = $urandom_range(0, 9);
    if ($urandom_range(0, 7) == 0) a = $urandom();
    else if ($urandom_range(0, 1) == 0) a = 32'(MEM_BASE + $urandom_range(0, 63));
    else a = 32'(MEM_BASE + $urandom_range(0, DEPTH - 1));
    if (sel <= 2)      set_op(0, 0, 1'($urandom_range(0, 1)), 4'($urandom()), $urandom(), $urandom());
    else if (sel <= 5) set_op(0, 1, 1'($urandom_range(0, 1)), 4'($urandom()), a, $urandom());
    else if (sel <= 8) set_op(1, 0, 1'($urandom_range(0, 1)), 4'($urandom()), a, $urandom());
    else               set_op(1, 1, 1'($urandom_range(0, 1)), 4'($urandom()), a, $urandom());
  endtask

  task automatic test_random();
    int cyc = 0, due = 0, cur_kind = -1, cur_acc = 0, lat, kind, bad = 0;
    logic accept, exp_valid, exp_we, exp_re;
    logic [37:0] exp;
    for (int i = 0; i < DEPTH; i++) preload(i, 8'($urandom()));
    rand_op();
    while (cyc < 1010) begin
      exp_valid = (due_q.size() > 0 && due_q[0] == cyc);
      n_checks++;
      if (bus.o_wb_valid !== exp_valid) begin
        n_errors++; $display("FAIL rand_wb_valid cyc=%0d got=%b exp=%b", cyc, bus.o_wb_valid, exp_valid);
      end
      if (exp_valid) begin
        if (bus.o_wb_valid === 1'b1) begin
          n_checks++;
          if ({bus.o_fault, bus.o_wb_en, bus.o_wb_rd, bus.o_wb_data} !== exp_q[0]) begin
            n_errors++; $display("FAIL rand_wb cyc=%0d got=%h exp=%h", cyc,
              {bus.o_fault, bus.o_wb_en, bus.o_wb_rd, bus.o_wb_data}, exp_q[0]);
          end
        end
        void'(exp_q.pop_front()); void'(due_q.pop_front());
      end
      n_checks++;
      if (bus.o_ready !== (cyc >= due)) begin
        n_errors++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", cyc, bus.o_ready, cyc >= due);
      end
      exp_we = (cur_kind == 1 && cyc >= cur_acc + 1 && cyc <= cur_acc + 4);
      exp_re = (cur_kind == 2 && cyc >= cur_acc + 1 && cyc <= cur_acc + 4);
      n_checks++;
      if ({bus.o_mem_we, bus.o_mem_re} !== {exp_we, exp_re}) begin
        n_errors++; $display("FAIL rand_strobe cyc=%0d we/re got=%b exp=%b", cyc, {bus.o_mem_we, bus.o_mem_re}, {exp_we, exp_re});
      end
      accept = bus.i_valid && bus.o_ready;
      if (accept) begin
        model_exec(bus.i_s_mem_r_en, bus.i_s_mem_w_en, bus.i_s_wb_en, bus.i_rd, bus.i_alu_res, bus.i_v_st, exp, lat, kind);
        due = cyc + lat;
        exp_q.push_back(exp); due_q.push_back(due);
        cur_kind = kind; cur_acc = cyc;
      end
      tick(); cyc++;
      if (cyc >= 1000) bus.i_valid = 1'b0;
      else if (accept) rand_op();
    end
    n_checks++;
    if (exp_q.size() != 0) begin n_errors++; $display("FAIL rand_pending got=%0d exp=0", exp_q.size()); end
    for (int i = 0; i < DEPTH; i++) if (ram[i] !== ref_mem[i]) bad++;
    n_checks++;
    if (bad != 0) begin n_errors++; $display("FAIL rand_ram_image bad_bytes got=%0d exp=0", bad); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_store();
    test_load();
    test_back_to_back();
    test_fault();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
